// File: rtl/seg_capture_pkg.sv
// Shared constants and types for the seven-segment readback monitor.
package seg_pkg;

   localparam int unsigned NUM_DIG = 8;
   localparam int unsigned SEG_W   = 8;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned PAT_W   = 7;
   localparam int unsigned VEC_W   = NUM_DIG * SEG_W;
   localparam int unsigned DIG_W   = NUM_DIG * NIB_W;
   localparam int unsigned CNT_W   = 8;

   // a..g patterns, a in the MSB, 1 = segment lit
   localparam logic [PAT_W-1:0] SEG_HEX_0 = 7'b1111110;
   localparam logic [PAT_W-1:0] SEG_HEX_1 = 7'b0110000;
   localparam logic [PAT_W-1:0] SEG_HEX_2 = 7'b1101101;
   localparam logic [PAT_W-1:0] SEG_HEX_3 = 7'b1111001;
   localparam logic [PAT_W-1:0] SEG_HEX_4 = 7'b0110011;
   localparam logic [PAT_W-1:0] SEG_HEX_5 = 7'b1011011;
   localparam logic [PAT_W-1:0] SEG_HEX_6 = 7'b1011111;
   localparam logic [PAT_W-1:0] SEG_HEX_7 = 7'b1110000;
   localparam logic [PAT_W-1:0] SEG_HEX_8 = 7'b1111111;
   localparam logic [PAT_W-1:0] SEG_HEX_9 = 7'b1111011;
   localparam logic [PAT_W-1:0] SEG_HEX_A = 7'b1110111;
   localparam logic [PAT_W-1:0] SEG_HEX_B = 7'b0011111;
   localparam logic [PAT_W-1:0] SEG_HEX_C = 7'b1001110;
   localparam logic [PAT_W-1:0] SEG_HEX_D = 7'b0111101;
   localparam logic [PAT_W-1:0] SEG_HEX_E = 7'b1001111;
   localparam logic [PAT_W-1:0] SEG_HEX_F = 7'b1000111;

   // Clears the dp bit (bit0) of every digit in the sampled vector
   localparam logic [VEC_W-1:0] NO_DP_MASK = {NUM_DIG{8'hFE}};

   typedef enum logic {
      SETTLE = 1'b0,
      HOLD   = 1'b1
   } state_e;

endpackage

// File: rtl/seg_capture_if.sv
// Pin and snapshot handshake bundle for seg_capture.
interface seg_capture_if;
   import seg_pkg::*;

   logic [SEG_W-1:0] i_seg0;
   logic [SEG_W-1:0] i_seg1;
   logic [SEG_W-1:0] i_seg2;
   logic [SEG_W-1:0] i_seg3;
   logic [SEG_W-1:0] i_seg4;
   logic [SEG_W-1:0] i_seg5;
   logic [SEG_W-1:0] i_seg6;
   logic [SEG_W-1:0] i_seg7;
   logic [DIG_W-1:0] o_digits;
   logic [NUM_DIG-1:0] o_invalid;
   logic [NUM_DIG-1:0] o_dp;
   logic             o_valid;
   logic             i_ready;
   logic             o_ovf;

   modport slave (
      input  i_seg0, i_seg1, i_seg2, i_seg3, i_seg4, i_seg5, i_seg6, i_seg7,
      input  i_ready,
      output o_digits, o_invalid, o_dp, o_valid, o_ovf
   );

   modport master (
      output i_seg0, i_seg1, i_seg2, i_seg3, i_seg4, i_seg5, i_seg6, i_seg7,
      output i_ready,
      input  o_digits, o_invalid, o_dp, o_valid, o_ovf
   );
endinterface

// File: rtl/seg_decode7.sv
// Combinational a..g to hex nibble decoder; unknown patterns flag invalid.
module seg_decode7
   import seg_pkg::*;
(
   input  logic [PAT_W-1:0] seg_i,
   output logic [NIB_W-1:0] nib_o,
   output logic             invalid_o
);

   // Table lookup; anything not in the hex set decodes to 0 and is flagged
   always_comb begin
      nib_o     = '0;
      invalid_o = 1'b0;
      case (seg_i)
         SEG_HEX_0: nib_o = 4'h0;
         SEG_HEX_1: nib_o = 4'h1;
         SEG_HEX_2: nib_o = 4'h2;
         SEG_HEX_3: nib_o = 4'h3;
         SEG_HEX_4: nib_o = 4'h4;
         SEG_HEX_5: nib_o = 4'h5;
         SEG_HEX_6: nib_o = 4'h6;
         SEG_HEX_7: nib_o = 4'h7;
         SEG_HEX_8: nib_o = 4'h8;
         SEG_HEX_9: nib_o = 4'h9;
         SEG_HEX_A: nib_o = 4'hA;
         SEG_HEX_B: nib_o = 4'hB;
         SEG_HEX_C: nib_o = 4'hC;
         SEG_HEX_D: nib_o = 4'hD;
         SEG_HEX_E: nib_o = 4'hE;
         SEG_HEX_F: nib_o = 4'hF;
         default:   invalid_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_capture.sv
// Seven-segment bank readback monitor: waits for the bank to settle, decodes
// it and offers one snapshot at a time over valid/ready.
// Build option: define SEG_CAPTURE_DP_EN to include the dp bits in change
// detection and report them on o_dp; otherwise dp is ignored and o_dp is 0.
module seg_capture
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYC = 4
) (
   input logic          clk,
   input logic          rst,
   seg_capture_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

   logic [VEC_W-1:0]   pin_c;
   logic [VEC_W-1:0]   smp_q, smp_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               qual_c;
   logic               first_qual_c;
   logic [VEC_W-1:0]   last_q;
   logic               emitted_q;
   state_e             state_q;
   logic               valid_q;
   logic               ovf_q;
   logic [DIG_W-1:0]   digits_q;
   logic [NUM_DIG-1:0] invalid_q;
   logic [DIG_W-1:0]   dec_nib_c;
   logic [NUM_DIG-1:0] dec_inv_c;

   // Invert the active-low pins into one vector, digit n at [8n+7:8n]
   always_comb begin
      pin_c = ~{bus.i_seg7, bus.i_seg6, bus.i_seg5, bus.i_seg4,
                bus.i_seg3, bus.i_seg2, bus.i_seg1, bus.i_seg0};
`ifdef SEG_CAPTURE_DP_EN
      pin_c = pin_c;
`else
      pin_c = pin_c & NO_DP_MASK;
`endif
   end

   // Stability window: restart on any change, saturate once qualified
   always_comb begin
      smp_d = pin_c;
      cnt_d = cnt_q;
      if (pin_c != smp_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign qual_c       = (cnt_q == CNT_MAX);
   assign first_qual_c = (cnt_d == CNT_MAX) && (!qual_c || (pin_c != smp_q));

   // Decode the currently sampled vector for latching into the snapshot
   for (genvar n = 0; n < NUM_DIG; n++) begin : g_dec
      seg_decode7 u_dec (
         .seg_i     (smp_q[SEG_W*n+7 -: PAT_W]),
         .nib_o     (dec_nib_c[NIB_W*n +: NIB_W]),
         .invalid_o (dec_inv_c[n])
      );
   end

`ifdef SEG_CAPTURE_DP_EN
   logic [NUM_DIG-1:0] dp_c;
   logic [NUM_DIG-1:0] dp_q;

   // dp bit of every sampled digit
   always_comb begin
      dp_c = '0;
      for (int n = 0; n < NUM_DIG; n++) begin
         dp_c[n] = smp_q[SEG_W*n];
      end
   end

   // dp snapshot follows the same latch point as the decoded digits
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_q <= '0;
      end else if (state_q == SETTLE && qual_c && (!emitted_q || smp_q != last_q)) begin
         dp_q <= dp_c;
      end
   end

   assign bus.o_dp = dp_q;
`else
   assign bus.o_dp = '0;
`endif

   // Sampler, settle/hold FSM and snapshot registers
   always_ff @(posedge clk) begin
      if (rst) begin
         smp_q     <= '0;
         cnt_q     <= '0;
         last_q    <= '0;
         emitted_q <= 1'b0;
         state_q   <= SETTLE;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         digits_q  <= '0;
         invalid_q <= '0;
      end else begin
         smp_q <= smp_d;
         cnt_q <= cnt_d;
         case (state_q)
            SETTLE: begin
               if (qual_c && (!emitted_q || smp_q != last_q)) begin
                  digits_q  <= dec_nib_c;
                  invalid_q <= dec_inv_c;
                  last_q    <= smp_q;
                  emitted_q <= 1'b1;
                  valid_q   <= 1'b1;
                  state_q   <= HOLD;
               end
            end
            HOLD: begin
               if (valid_q && bus.i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= SETTLE;
               end
               if (first_qual_c && (smp_d != last_q)) begin
                  ovf_q <= 1'b1;
               end
            end
            default: state_q <= SETTLE;
         endcase
      end
   end

   assign bus.o_digits  = digits_q;
   assign bus.o_invalid = invalid_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_ovf     = ovf_q;

endmodule

// File: doc/seg_capture.md
# seg_capture

Display-side readback monitor for the 8-digit seven-segment bank. It samples the eight active-low segment buses driven toward the board and waits for the whole bank to hold steady. It then decodes each digit back to a hex nibble, flags undecodable patterns and presents one snapshot through a valid/ready handshake. It sits beside the segment driver and feeds the self-check and trace logic.

## Interface
Parameters:
- STABLE_CYC, 4: consecutive sampled edges the full bank must hold unchanged before it qualifies; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- i_seg0..i_seg7  in  8 each  active-low segment pins per digit; after inversion bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- o_digits  out  32  decoded nibbles; digit n occupies bits [4n+3:4n].
- o_invalid  out  8  bit n set when digit n's a..g pattern is not in the hex table.
- o_dp  out  8  bit n equals digit n's dp (active-high).
- o_valid  out  1  snapshot available.
- i_ready  in  1  consumer accepts the snapshot.
- o_ovf  out  1  sticky: a distinct pattern qualified while a snapshot was pending.

## Operation
- Hex table (a..g, 1 = lit):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Any other a..g pattern, blank included, sets o_invalid[n] and forces nibble 0.
- smp register: captures the 64-bit inverted pin vector every edge.
- cnt register:
  - cleared when the incoming vector differs from smp;
  - otherwise increments, saturating at STABLE_CYC-1.
- The vector is "qualified" when cnt == STABLE_CYC-1.
- State SETTLE:
  - A qualified vector that differs from the last-emitted vector, or any qualified vector when nothing has been emitted since reset, is latched into o_digits/o_invalid/o_dp.
  - The latched vector becomes the last-emitted vector, o_valid is set and the FSM goes to HOLD.
- State HOLD:
  - Outputs are frozen.
  - If o_valid && i_ready on an edge, clear o_valid and go to SETTLE.
  - On the edge where cnt first reaches STABLE_CYC-1 with a vector different from the held one, set o_ovf. That vector is not queued.
- On returning to SETTLE with the pins already qualified and different, the snapshot is emitted on the next edge.
- Reset:
  - o_valid=0, o_digits=0, o_invalid=0, o_dp=0, o_ovf=0, cnt=0, state SETTLE, "emitted" flag cleared.
  - Reset mid-HOLD discards the pending snapshot.

## Timing
- A vector first sampled into smp at edge k and held through edge k+STABLE_CYC-1 drives o_valid=1 after edge k+STABLE_CYC.
- A change on any pin restarts the window.
- Handshake: transfer occurs on an edge with o_valid&&i_ready; o_valid is low the following cycle.
  - Minimum spacing between snapshots is 2 cycles.
  - i_ready may be held high permanently.
- o_valid never drops without a transfer or reset.
- o_digits, o_invalid and o_dp are stable while o_valid=1.
- o_ovf clears only on rst.

## Configuration
- SEG_CAPTURE_DP_EN defined:
  - dp bits participate in change detection.
  - o_dp reports them.
- Not defined:
  - dp bits are masked to 0 before smp, so a dp-only change never restarts the window or triggers a snapshot.
  - o_dp is tied to 0.

## Structure
- Package seg_pkg:
  - the 16 hex pattern constants;
  - NUM_DIG=8;
  - SETTLE/HOLD state enum.
- Sub-module seg_decode7: combinational decoder taking a 7-bit a..g pattern and returning nibble + invalid; instantiated 8 times.

## Test plan
- Reset, then drive all digits with the active-low pattern for "0" (0x03) and dp off, STABLE_CYC=4, i_ready=1:
  - o_valid pulses once, 5 edges after the first sample;
  - o_digits=0x00000000, o_invalid=0.
- Digit n shows n (i_seg3=0x0D):
  - o_digits=0x76543210.
  - Then set digit 2 to raw a..g 1010101 → o_invalid=0x04 and o_digits[11:8]=0.
- Toggle i_seg5 every 3 cycles with STABLE_CYC=4 → o_valid never asserts; stop toggling → one snapshot 5 edges later.
- i_ready=0 with snapshot "11111111" held, then drive stable "22222222":
  - o_ovf=1 and o_digits unchanged;
  - raise i_ready → "11111111" transfers, then "22222222" emits 2 edges later.
- Hold a snapshot pending and assert rst → all outputs 0 next edge; the same stable pins then re-emit after release.
- Drive a dp-only change:
  - with SEG_CAPTURE_DP_EN → new snapshot with o_dp updated;
  - without it → no snapshot and o_dp=0.
